// File: rtl/seg7_pkg.sv
// Shared constants, FSM state type and glyph table for the 6-digit
// multiplexed seven-segment scan controller.
package seg7_pkg;

    localparam int NUM_DIGITS = 6;

    localparam logic [4:0] CODE_DASH  = 5'h10;
    localparam logic [4:0] CODE_BLANK = 5'h11;

    typedef enum logic {
        ST_SHOW,
        ST_BLANK
    } scan_state_t;

    // Segment order {a,b,c,d,e,f,g}, a in the MSB.
    localparam logic [6:0] GLYPH_HEX [16] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
        7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
    };

    function automatic logic [6:0] glyph(input logic [4:0] code);
        logic [6:0] seg;
        seg = '0;
        if (!code[4]) begin
            seg = GLYPH_HEX[code[3:0]];
        end else if (code == CODE_DASH) begin
            seg = 7'b0000001;
        end
        return seg;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational display-code to segment decoder; output is {a,b,c,d,e,f,g}.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [4:0] i_code,
    output logic [6:0] o_seg
);

    assign o_seg = glyph(i_code);

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Six-digit multiplexed seven-segment scanner: digit register file,
// SHOW/BLANK dwell FSM, frame counter with blink phase, registered outputs.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int PRESCALE     = 1000,
    parameter int BLANK_CYCLES = 2,
    parameter int BLINK_DIV    = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [2:0] wr_addr,
    input  logic [4:0] wr_data,
    input  logic [5:0] blink_mask,
    output logic       com3,
    output logic       com4,
    output logic       com5,
    output logic       com6,
    output logic       com7,
    output logic       com8,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       d,
    output logic       e,
    output logic       f,
    output logic       g,
    output logic       frame_done
);

    localparam int CNT_MAX = (PRESCALE > BLANK_CYCLES) ? PRESCALE : BLANK_CYCLES;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int FW      = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [4:0]    r_regs [NUM_DIGITS];
    scan_state_t   r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic [2:0]    r_digit, w_digit_nxt;
    logic [FW-1:0] r_frame;
    logic          r_blink_phase;
    logic          w_wrap;
    logic          w_last_show;
    logic          w_last_blank;

    logic [5:0]    r_com;
    logic [6:0]    r_seg;
    logic          r_frame_done;

    logic [4:0]    w_code;
    logic [6:0]    w_glyph;

    assign w_last_show  = (r_cnt == CW'(PRESCALE - 1));
    assign w_last_blank = (BLANK_CYCLES == 0) ? 1'b1 : (r_cnt == CW'(BLANK_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_SHOW;
            r_cnt   <= '0;
            r_digit <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_digit <= w_digit_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + CW'(1);
        w_digit_nxt = r_digit;
        w_wrap      = 1'b0;
        unique case (r_state)
            ST_SHOW: begin
                if (w_last_show) begin
                    w_cnt_nxt = '0;
                    if (BLANK_CYCLES == 0) begin
                        w_wrap      = (r_digit == 3'(NUM_DIGITS - 1));
                        w_digit_nxt = w_wrap ? 3'd0 : r_digit + 3'd1;
                    end else begin
                        w_state_nxt = ST_BLANK;
                    end
                end
            end
            ST_BLANK: begin
                if (w_last_blank) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_SHOW;
                    w_wrap      = (r_digit == 3'(NUM_DIGITS - 1));
                    w_digit_nxt = w_wrap ? 3'd0 : r_digit + 3'd1;
                end
            end
            default: begin
                w_state_nxt = ST_SHOW;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame       <= '0;
            r_blink_phase <= 1'b0;
        end else if (w_wrap) begin
            if (r_frame == FW'(BLINK_DIV - 1)) begin
                r_frame       <= '0;
                r_blink_phase <= ~r_blink_phase;
            end else begin
                r_frame <= r_frame + FW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                r_regs[i] <= CODE_BLANK;
            end
        end else if (wr_en && (wr_addr < 3'(NUM_DIGITS))) begin
            r_regs[wr_addr] <= wr_data;
        end
    end

    // Forward a same-edge write so the new glyph shows right after the write edge.
    assign w_code = (wr_en && (wr_addr == r_digit)) ? wr_data : r_regs[r_digit];

    seg7_decode u_decode (
        .i_code (w_code),
        .o_seg  (w_glyph)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_com        <= '0;
            r_seg        <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_com        <= '0;
            r_seg        <= '0;
            r_frame_done <= w_wrap;
            if (r_state == ST_SHOW) begin
                r_com <= 6'(1) << r_digit;
                if (!(r_blink_phase && blink_mask[r_digit])) begin
                    r_seg <= w_glyph;
                end
            end
        end
    end

    assign {com8, com7, com6, com5, com4, com3} = r_com;
    assign {a, b, c, d, e, f, g}                = r_seg;
    assign frame_done                           = r_frame_done;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: a BLANK_CYCLES=2 and a BLANK_CYCLES=0 instance
// checked every cycle against a time-position reference model.
module tb_seg7_scan_ctrl;

    localparam int PRE  = 4;
    localparam int BDIV = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [2:0] wr_addr = '0;
    logic [4:0] wr_data = '0;
    logic [5:0] blink_mask = '0;

    always #5 clk = ~clk;

    logic u0_com3, u0_com4, u0_com5, u0_com6, u0_com7, u0_com8;
    logic u0_a, u0_b, u0_c, u0_d, u0_e, u0_f, u0_g, u0_fd;
    logic u1_com3, u1_com4, u1_com5, u1_com6, u1_com7, u1_com8;
    logic u1_a, u1_b, u1_c, u1_d, u1_e, u1_f, u1_g, u1_fd;

    seg7_scan_ctrl #(.PRESCALE(PRE), .BLANK_CYCLES(2), .BLINK_DIV(BDIV)) u0 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .blink_mask(blink_mask),
        .com3(u0_com3), .com4(u0_com4), .com5(u0_com5), .com6(u0_com6), .com7(u0_com7), .com8(u0_com8),
        .a(u0_a), .b(u0_b), .c(u0_c), .d(u0_d), .e(u0_e), .f(u0_f), .g(u0_g),
        .frame_done(u0_fd)
    );

    seg7_scan_ctrl #(.PRESCALE(PRE), .BLANK_CYCLES(0), .BLINK_DIV(BDIV)) u1 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .blink_mask(blink_mask),
        .com3(u1_com3), .com4(u1_com4), .com5(u1_com5), .com6(u1_com6), .com7(u1_com7), .com8(u1_com8),
        .a(u1_a), .b(u1_b), .c(u1_c), .d(u1_d), .e(u1_e), .f(u1_f), .g(u1_g),
        .frame_done(u1_fd)
    );

    // {com8..com3, a..g, frame_done}
    logic [13:0] v0, v1;
    assign v0 = {u0_com8, u0_com7, u0_com6, u0_com5, u0_com4, u0_com3,
                 u0_a, u0_b, u0_c, u0_d, u0_e, u0_f, u0_g, u0_fd};
    assign v1 = {u1_com8, u1_com7, u1_com6, u1_com5, u1_com4, u1_com3,
                 u1_a, u1_b, u1_c, u1_d, u1_e, u1_f, u1_g, u1_fd};

    int checks = 0;
    int errors = 0;

    // Reference model: t = output cycle index since reset release (-1 in reset).
    int         t = -1;
    logic [4:0] m_regs [6];
    logic [5:0] mask_q = '0;

    string glyph_str [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                              "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};

    always @(posedge clk) begin
        mask_q = blink_mask;
        if (rst) begin
            t = -1;
            for (int i = 0; i < 6; i++) m_regs[i] = 5'h11;
        end else begin
            t = t + 1;
            if (wr_en && wr_addr <= 3'd5) m_regs[wr_addr] = wr_data;
        end
    end

    function automatic logic [6:0] glyph_bits(input logic [4:0] code);
        logic [6:0] s;
        string      gs;
        s = '0;
        if (code < 5'd16) begin
            gs = glyph_str[code[3:0]];
            for (int i = 0; i < gs.len(); i++) s[6 - (gs[i] - 8'h61)] = 1'b1;
        end else if (code == 5'h10) begin
            s = 7'b0000001;
        end
        return s;
    endfunction

    function automatic logic [13:0] expect_vec(input int blk);
        int per, p, pos, dig, off, phase;
        logic [5:0] com;
        logic [6:0] seg;
        logic       fd;
        com = '0; seg = '0; fd = 1'b0;
        if (t >= 0) begin
            per   = PRE + blk;
            p     = 6 * per;
            pos   = t % p;
            dig   = pos / per;
            off   = pos % per;
            phase = ((t / p) / BDIV) % 2;
            fd    = (pos == p - 1);
            if (off < PRE) begin
                com[dig] = 1'b1;
                if (!(phase == 1 && mask_q[dig])) seg = glyph_bits(m_regs[dig]);
            end
        end
        return {com, seg, fd};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (v0 !== 14'd0 || v1 !== 14'd0) begin
                errors++;
                $display("FAIL reset_hold: got u0=%h u1=%h, want 0000", v0, v1);
            end
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (v0 !== 14'h0100 || v1 !== 14'h0100) begin
            errors++;
            $display("FAIL reset_release: got u0=%h u1=%h, want 0100 (com3 only)", v0, v1);
        end
    endtask

    task automatic test_idle_scan();
        int last_fd, gap_err;
        last_fd = -1;
        gap_err = 0;
        repeat (110) begin
            @(negedge clk);
            checks++;
            if (v0 !== expect_vec(2) || v1 !== expect_vec(0)) begin
                errors++;
                $display("FAIL idle_scan t=%0d: got u0=%h u1=%h, want u0=%h u1=%h",
                         t, v0, v1, expect_vec(2), expect_vec(0));
            end
            if (u0_fd) begin
                if (last_fd >= 0 && t - last_fd != 36) gap_err++;
                last_fd = t;
            end
        end
        checks++;
        if (gap_err != 0 || last_fd < 0) begin
            errors++;
            $display("FAIL frame_period: got %0d bad gaps (last pulse t=%0d), want 36-cycle spacing", gap_err, last_fd);
        end
    endtask

    task automatic test_digit_writes();
        for (int i = 0; i < 90; i++) begin
            @(negedge clk);
            checks++;
            if (v0 !== expect_vec(2) || v1 !== expect_vec(0)) begin
                errors++;
                $display("FAIL digit_writes t=%0d: got u0=%h u1=%h, want u0=%h u1=%h",
                         t, v0, v1, expect_vec(2), expect_vec(0));
            end
            if (i < 6) begin
                wr_en = 1'b1; wr_addr = 3'(i); wr_data = 5'(i);
            end else begin
                wr_en = 1'b0;
            end
        end
    endtask

    task automatic test_live_write();
        int n, pos, dig, off, tries;
        logic found;
        blink_mask = '0;
        found = 1'b0;
        dig   = 0;
        tries = 0;
        while (!found && tries < 50) begin
            @(negedge clk);
            tries++;
            n   = t + 1;
            pos = n % 36;
            dig = pos / 6;
            off = pos % 6;
            if (off < PRE - 1 && m_regs[dig] != 5'h08) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL live_write_search: got no SHOW slot in 50 cycles, want one");
        end else begin
            wr_en = 1'b1; wr_addr = 3'(dig); wr_data = 5'h08;
            @(negedge clk);
            wr_en = 1'b0;
            checks++;
            if (v0[7:1] !== 7'h7F || v0 !== expect_vec(2)) begin
                errors++;
                $display("FAIL live_write: got u0=%h, want %h (segments 7f)", v0, expect_vec(2));
            end
        end
        for (int i = 0; i < 12; i++) begin
            wr_en = 1'b1; wr_addr = 3'd6 + 3'(i % 2); wr_data = 5'($urandom_range(0, 31));
            @(negedge clk);
            checks++;
            if (v0 !== expect_vec(2) || v1 !== expect_vec(0)) begin
                errors++;
                $display("FAIL ignored_addr t=%0d: got u0=%h u1=%h, want u0=%h u1=%h",
                         t, v0, v1, expect_vec(2), expect_vec(0));
            end
        end
        wr_en = 1'b0;
    endtask

    task automatic test_blink();
        int on_cnt, off_cnt;
        on_cnt = 0; off_cnt = 0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        wr_en = 1'b1; wr_addr = 3'd0; wr_data = 5'h08; blink_mask = 6'b000001;
        for (int i = 0; i < 144; i++) begin
            @(negedge clk);
            wr_en = 1'b0;
            checks++;
            if (v0 !== expect_vec(2) || v1 !== expect_vec(0)) begin
                errors++;
                $display("FAIL blink t=%0d: got u0=%h u1=%h, want u0=%h u1=%h",
                         t, v0, v1, expect_vec(2), expect_vec(0));
            end
            if (u0_com3 && v0[7:1] == 7'h7F) on_cnt++;
            if (u0_com3 && v0[7:1] == 7'h00) off_cnt++;
        end
        checks++;
        if (on_cnt != 8 || off_cnt != 8) begin
            errors++;
            $display("FAIL blink_counts: got on=%0d off=%0d, want on=8 off=8", on_cnt, off_cnt);
        end
        blink_mask = '0;
    endtask

    task automatic test_reset_mid_blank();
        int pos, tries;
        logic found;
        logic saw_fd;
        found = 1'b0; tries = 0; saw_fd = 1'b0;
        while (!found && tries < 100) begin
            @(negedge clk);
            tries++;
            pos = t % 36;
            if (pos / 6 == 3 && pos % 6 >= PRE) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL rst_blank_search: got no digit-3 BLANK in 100 cycles, want one");
        end
        rst = 1'b1; wr_en = 1'b1; wr_addr = 3'd0; wr_data = 5'h08;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (v0 !== 14'd0 || v1 !== 14'd0) begin
                errors++;
                $display("FAIL rst_mid_blank: got u0=%h u1=%h, want 0000", v0, v1);
            end
        end
        rst = 1'b0; wr_en = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            checks++;
            if (v0 !== expect_vec(2) || v1 !== expect_vec(0) || v0[7:1] !== 7'h00) begin
                errors++;
                $display("FAIL rst_restart t=%0d: got u0=%h u1=%h, want u0=%h u1=%h",
                         t, v0, v1, expect_vec(2), expect_vec(0));
            end
            if (i < 35 && u0_fd) saw_fd = 1'b1;
        end
        checks++;
        if (saw_fd) begin
            errors++;
            $display("FAIL rst_no_partial_frame: got frame_done before first full frame, want none");
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            checks++;
            if (v0 !== expect_vec(2) || v1 !== expect_vec(0)) begin
                errors++;
                $display("FAIL random t=%0d: got u0=%h u1=%h, want u0=%h u1=%h",
                         t, v0, v1, expect_vec(2), expect_vec(0));
            end
            wr_en   = ($urandom_range(0, 3) == 0);
            wr_addr = 3'($urandom_range(0, 7));
            wr_data = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 15) == 0) blink_mask = 6'($urandom_range(0, 63));
        end
        wr_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_idle_scan();
        test_digit_writes();
        test_live_write();
        test_blink();
        test_reset_mid_blank();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg7_scan_ctrl.md
SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

Interface
REQ-001 SHALL have parameter PRESCALE, default 1000: clock cycles each digit is driven (SHOW dwell), legal range >=1.
REQ-002 SHALL have parameter BLANK_CYCLES, default 2: all-commons-off cycles between digits, legal range >=0; 0 skips BLANK.
REQ-003 SHALL have parameter BLINK_DIV, default 64: completed scan frames per blink half-period, legal range >=1.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge; one clock; reset is synchronous and active-high.
REQ-005 SHALL have port rst  input  1  synchronous active-high reset.
REQ-006 SHALL have port wr_en  input  1  write strobe for digit register file.
REQ-007 SHALL have port wr_addr  input  3  digit index 0..5; 6..7 ignored.
REQ-008 SHALL have port wr_data  input  5  display code.
REQ-009 SHALL have port blink_mask  input  6  per-digit blink enable, bit n = digit n.
REQ-010 SHALL have ports com3..com8  output  1 each  digit commons, active-high, digit 0 = com3 ... digit 5 = com8.
REQ-011 SHALL have ports a,b,c,d,e,f,g  output  1 each  segments, active-high.
REQ-012 SHALL have port frame_done  output  1  one-cycle pulse when digit 5 dwell (incl. its BLANK) ends.

Function
REQ-013 SHALL hold six 5-bit digit registers; wr_en with wr_addr<=5 writes wr_data at the clock edge; wr_addr 6..7 changes nothing.
REQ-014 SHALL decode codes: 0x00-0x0F hex glyphs (0=abcdef, 1=bc, 8=abcdefg, A=abcefg, F=aefg), 0x10 = g only (dash), 0x11-0x1F = all segments off.
REQ-015 SHALL run a 2-state FSM: SHOW (one common high, segments = decoded glyph) and BLANK (all commons and segments low).
REQ-016 SHALL stay in SHOW exactly PRESCALE cycles, then BLANK exactly BLANK_CYCLES cycles, then advance digit index and re-enter SHOW.
REQ-017 SHALL advance digit index 0->1->...->5->0; wrap from 5 to 0 marks frame completion and pulses frame_done in that same cycle.
REQ-018 SHALL keep commons strictly one-hot in SHOW and all-zero in BLANK; never two commons high in any cycle.
REQ-019 SHALL register all outputs; a write to the currently displayed digit appears on segments the cycle after the write edge.
REQ-020 SHALL count completed frames modulo BLINK_DIV and toggle blink_phase on each count wrap.
REQ-021 SHALL force segments low (common still driven) for a digit whose blink_mask bit is 1 while blink_phase=1.
REQ-022 SHALL sample blink_mask each cycle; changes take effect on the next output update with no FSM disturbance.
REQ-023 SHALL, with BLANK_CYCLES=0, go SHOW digit n directly to SHOW digit n+1 with no all-off cycle.

Reset
REQ-024 SHALL on rst=1 set all digit registers to 0x11 (blank), digit index 0, FSM SHOW, dwell/blank counters 0, frame counter 0, blink_phase 0.
REQ-025 SHALL drive all com*, a..g and frame_done low while rst=1; first cycle after release shows com3=1 with segments off.
REQ-026 SHALL let rst mid-frame or mid-BLANK restart the scan at digit 0 with no partial frame_done pulse.
REQ-027 SHALL give rst priority over a simultaneous wr_en.

Structure
REQ-028 SHALL place NUM_DIGITS=6, code constants (CODE_DASH=0x10, CODE_BLANK=0x11), FSM state enum and glyph table in shared package seg7_pkg.
REQ-029 SHALL instantiate one combinational sub-module seg7_decode (5-bit code in, 7 segments out); scan counter, FSM and register file stay in the top.

Verification (PRESCALE=4, BLANK_CYCLES=2, BLINK_DIV=2)
REQ-030 Reset release, no writes -> com3..com8 one-hot in turn, 4 cycles each, 2 all-off cycles between, segments all 0, frame_done every 36 cycles.
REQ-031 Write 0x00..0x05 to digits 0..5 -> during com3 segments=abcdef; during com4 segments=bc; during com5 abdeg.
REQ-032 Write 0x08 to the digit currently in SHOW -> a..g all 1 starting the cycle after the write edge; wr_addr=6 write -> no output change.
REQ-033 blink_mask=6'b000001, digit 0 = 0x08 -> digit 0 segments all on frames 0-1, off frames 2-3 (com3 still high), repeating; other digits unaffected.
REQ-034 Assert rst during BLANK after digit 3 -> outputs low during rst, restart at com3 after release, registers read back 0x11, no frame_done.
REQ-035 BLANK_CYCLES=0 build -> com3 high 4 cycles then com4 high next cycle, frame_done every 24 cycles, never zero or two commons high.
